// File: rtl/regfile_port_ctrl_pkg.sv
// Shared definitions for the register-file port controller.
// Holds the default register-file geometry, the controller state encoding
// and a small saturating-increment helper used by the starvation counter.
package regfile_port_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 4;
  localparam int REG_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_HWRITE = 3'd2,
    S_HREAD  = 3'd3,
    S_ACK    = 3'd4
  } state_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v == lim) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Host register-access bus.
//   req   : transaction request, level, held until ack
//   we    : 1 = write, 0 = read (stable while req is high)
//   addr  : register address (stable while req is high)
//   wdata : write data (stable while req is high)
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack, held until the next read ack
// master = host agent, slave = controller.
interface regfile_port_ctrl_if
  import regfile_port_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int DATA_W = REG_DATA_WIDTH
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sweep counter.
//   clk, rst     : clock, synchronous active-high reset
//   o_clr_addr   : register address being cleared this cycle
//   o_clr_last   : high in the cycle that clears the final register
// The counter is one bit wider than the address so that the sweep-done
// state (MSB set) is distinct from every address and freezes the count.
module regfile_clr_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_last
);

  localparam logic [ADDR_W:0] L_LAST = {1'b0, {ADDR_W{1'b1}}};

  logic [ADDR_W:0] r_clr_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (!r_clr_cnt[ADDR_W]) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign o_clr_addr = r_clr_cnt[ADDR_W-1:0];
  assign o_clr_last = (r_clr_cnt == L_LAST);

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file access controller.
// After reset it clears every register to zero, then shares the single
// write port between pipeline writeback (absolute priority) and a host
// agent, and serves host reads through the probe read port with
// forwarding of a same-cycle write.
//   clk, rst          : clock, synchronous active-high reset
//   wb_wena/waddr/wdata : pipeline writeback request
//   host              : host bus (slave side)
//   rf_wena/waddr/wdata : register-file write port
//   rf_probe_addr/data  : register-file probe read port
//   cpu_stall         : asks the pipeline to freeze
//   clr_busy          : clear sweep in progress
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
#(
  parameter int ADDR_W       = REG_ADDR_WIDTH,
  parameter int DATA_W       = REG_DATA_WIDTH,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wena,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  regfile_port_ctrl_if.slave host,
  output logic              rf_wena,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_probe_addr,
  input  logic [DATA_W-1:0] rf_probe_data,
  output logic              cpu_stall,
  output logic              clr_busy
);

  localparam logic [7:0] L_STARVE = 8'(STARVE_LIMIT);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [7:0]        r_starve_cnt;
  logic [DATA_W-1:0] r_host_rdata;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_last;
  logic              w_host_grant;

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .o_clr_addr (w_clr_addr),
    .o_clr_last (w_clr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    rf_wena       = wb_wena;
    rf_waddr      = wb_waddr;
    rf_wdata      = wb_wdata;
    rf_probe_addr = host.addr;
    host.ack      = 1'b0;
    clr_busy      = 1'b0;
    w_host_grant  = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        rf_wena       = 1'b1;
        rf_waddr      = w_clr_addr;
        rf_wdata      = '0;
        rf_probe_addr = '0;
        clr_busy      = 1'b1;
        if (w_clr_last) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (host.req) w_state_nxt = host.we ? S_HWRITE : S_HREAD;
      end
      S_HWRITE: begin
        // Writeback keeps the port; the host write waits for a free cycle.
        if (!wb_wena) begin
          rf_wena      = 1'b1;
          rf_waddr     = host.addr;
          rf_wdata     = host.wdata;
          w_host_grant = 1'b1;
          w_state_nxt  = S_ACK;
        end
      end
      S_HREAD: w_state_nxt = S_ACK;
      S_ACK: begin
        host.ack    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Counts cycles a pending host write has lost to writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_host_grant) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_HWRITE && wb_wena) begin
      r_starve_cnt <= sat_inc8(r_starve_cnt, L_STARVE);
    end
  end

  // The probe port is unforwarded, so a write to the same register in the
  // capture cycle must be taken from the write port instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_rdata <= '0;
    end else if (r_state == S_HREAD) begin
      r_host_rdata <= (rf_wena && rf_waddr == host.addr) ? rf_wdata : rf_probe_data;
    end
  end

  assign host.rdata = r_host_rdata;
  assign cpu_stall  = clr_busy || (r_starve_cnt == L_STARVE);

endmodule
